// File: rtl/ntr_pkg.sv
// Shared types and constants for the NTR cartridge command-bus receiver.
package ntr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DUMMY,
    CMD,
    WAIT_DESEL
  } ntr_state_t;

  localparam int         NTR_CMD_LEN = 8;
  localparam logic [7:0] NTR_HDR_FF  = 8'hFF;

endpackage

// File: rtl/ntr_sync.sv
// Multi-stage synchronizer with a registered output stage and rising-edge detector.
// Output value and edge pulse leave the final register together, so they stay aligned.
module ntr_sync #(
  parameter int                DATA_W  = 1,
  parameter int                STAGES  = 2,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] rise
);

  logic [DATA_W-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= RST_VAL;
      q    <= RST_VAL;
      rise <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      q    <= sync_q[STAGES-1];
      rise <= sync_q[STAGES-1] & ~q;
    end
  end

endmodule

// File: rtl/ntr_top.sv
// NTR command-bus receiver: captures 8-byte commands from the oversampled card bus
// and shows a summary of the last complete command on four LEDs.
module ntr_top
  import ntr_pkg::*;
#(
  parameter int CMD_LEN     = NTR_CMD_LEN,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ntr_data,
  input  logic       ntr_clk,
  input  logic       ntr_cs1,
  output logic [3:0] led
);

  localparam logic [2:0] LAST_IDX = 3'(CMD_LEN - 1);

  logic       clk_s;
  logic       clk_rise;
  logic       cs1_s;
  logic       cs1_rise_unused;
  logic [7:0] data_s;
  logic [7:0] data_rise_unused;

  ntr_sync #(.DATA_W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ntr_clk),
    .q     (clk_s),
    .rise  (clk_rise)
  );

  // Select resets to the deselected level so the bus looks idle out of reset.
  ntr_sync #(.DATA_W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs1 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ntr_cs1),
    .q     (cs1_s),
    .rise  (cs1_rise_unused)
  );

  ntr_sync #(.DATA_W(8), .STAGES(SYNC_STAGES), .RST_VAL(8'h00)) u_sync_data (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ntr_data),
    .q     (data_s),
    .rise  (data_rise_unused)
  );

  ntr_state_t state;
  logic [2:0] count;
  logic [7:0] cmd [CMD_LEN];
  logic [7:0] hdr;
  logic       clk_s_unused;

  assign clk_s_unused = clk_s;
  // With a one-byte command the header is the byte arriving now.
  assign hdr = (count == 3'd0) ? data_s : cmd[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= 3'd0;
      led   <= 4'b0000;
      for (int i = 0; i < CMD_LEN; i++) cmd[i] <= 8'h00;
    end else if (cs1_s) begin
      // Deselect overrides any edge in the same cycle and drops partial commands.
      state <= IDLE;
      count <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          state <= DUMMY;
          count <= 3'd0;
        end
        DUMMY: begin
          if (clk_rise) begin
            state <= CMD;
            count <= 3'd0;
          end
        end
        CMD: begin
          if (clk_rise) begin
            cmd[count] <= data_s;
            count      <= count + 3'd1;
            if (count == LAST_IDX) begin
              led   <= {1'b1, (hdr == NTR_HDR_FF), data_s[1:0]};
              state <= WAIT_DESEL;
            end
          end
        end
        WAIT_DESEL: state <= WAIT_DESEL;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntr_top.sv
// Directed self-checking bench for ntr_top: commands, aborts, overrun and reset.
module tb_ntr_top;

  logic       clk;
  logic       rst_n;
  logic [7:0] ntr_data;
  logic       ntr_clk;
  logic       ntr_cs1;
  logic [3:0] led;

  int total;
  int bad;

  ntr_top #(.CMD_LEN(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ntr_data (ntr_data),
    .ntr_clk  (ntr_clk),
    .ntr_cs1  (ntr_cs1),
    .led      (led)
  );

  // clk rises at 5, 15, 25 ... so bus changes on multiples of 10 never race it.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One ntr_clk cycle, 4 clk periods per phase; data set during the low phase.
  task automatic ntr_edge(input logic [7:0] b);
    ntr_data = b;
    #40 ntr_clk = 1'b1;
    #40 ntr_clk = 1'b0;
  endtask

  task automatic select_and_dummy();
    ntr_cs1 = 1'b0;
    #40;
    ntr_edge(8'hA5);
  endtask

  task automatic deselect();
    ntr_cs1 = 1'b1;
    #80;
  endtask

  task automatic send_bytes(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) ntr_edge(v[63-8*i -: 8]);
  endtask

  // Seven bytes, then the eighth with an exact latency check around its edge.
  task automatic send_cmd_timed(input string name, input logic [63:0] v,
                                input logic [3:0] prev, input logic [3:0] exp);
    send_bytes(v, 7);
    ntr_data = v[7:0];
    #40 ntr_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (led !== prev) begin
      bad++;
      $display("FAIL %s_early: led=%b required=%b", name, led, prev);
    end
    @(posedge clk);
    #1;
    total++;
    if (led !== exp) begin
      bad++;
      $display("FAIL %s_latency: led=%b required=%b", name, led, exp);
    end
    #4 ntr_clk = 1'b0;
  endtask

  task automatic check_led(input string name, input logic [3:0] exp);
    total++;
    if (led !== exp) begin
      bad++;
      $display("FAIL %s: led=%b required=%b", name, led, exp);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ntr_cs1  = 1'b1;
    ntr_clk  = 1'b0;
    ntr_data = 8'h00;
    #40;
    check_led("reset_asserted", 4'b0000);
    rst_n = 1'b1;
    #60;
    check_led("reset_released", 4'b0000);
  endtask

  task automatic test_cmd_desel();
    select_and_dummy();
    send_cmd_timed("cmd_desel", 64'hFF00_0000_0000_0001, 4'b0000, 4'b1101);
    deselect();
    check_led("cmd_desel_after", 4'b1101);
  endtask

  task automatic test_cmd_nodesel();
    select_and_dummy();
    send_cmd_timed("cmd_nodesel", 64'hFF00_0000_0000_0000, 4'b1101, 4'b1100);
    #80;
    check_led("cmd_nodesel_hold", 4'b1100);
  endtask

  task automatic test_abort();
    deselect();
    select_and_dummy();
    send_bytes(64'h0001_0203_0400_0000, 5);
    deselect();
    check_led("abort_unchanged", 4'b1100);
    select_and_dummy();
    send_bytes(64'h1200_0000_0000_0002, 8);
    #80;
    check_led("abort_then_full", 4'b1010);
    deselect();
  endtask

  task automatic test_overrun();
    select_and_dummy();
    send_bytes(64'hFF00_0000_0000_0003, 8);
    #80;
    check_led("overrun_complete", 4'b1111);
    send_bytes(64'h0000_0000_0000_0000, 2);
    #80;
    check_led("overrun_ignored", 4'b1111);
    deselect();
  endtask

  task automatic test_reset_mid();
    select_and_dummy();
    send_bytes(64'hFF00_0000_0000_0000, 4);
    rst_n = 1'b0;
    #20;
    check_led("reset_mid_cleared", 4'b0000);
    rst_n = 1'b1;
    #20;
    send_bytes(64'h0000_0003_0000_0000, 4);
    #80;
    check_led("reset_mid_no_complete", 4'b0000);
    deselect();
    select_and_dummy();
    send_bytes(64'hFF00_0000_0000_0001, 8);
    #80;
    check_led("reset_mid_recover", 4'b1101);
    deselect();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_cmd_desel();
    test_cmd_nodesel();
    test_abort();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
